// File: rtl/cache_partition_arbiter_if.sv
// Request, cacheline-lookup and response signals shared by the partition arbiter
// and whatever drives it. The arbiter connects through the slave modport.
interface cache_partition_arbiter_if #(
    parameter int NUM_WAYS   = 4,
    parameter int ADDR_WIDTH = 8
);
    logic                  os_valid;
    logic [ADDR_WIDTH-1:0] os_addr;
    logic                  os_ready;
    logic                  user_valid;
    logic [ADDR_WIDTH-1:0] user_addr;
    logic                  user_ready;
    logic [NUM_WAYS-1:0]   os_way_mask;
    logic [NUM_WAYS-1:0]   user_way_mask;
    logic                  line_os_req;
    logic                  line_user_req;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [NUM_WAYS-1:0]   line_hitmap;
    logic                  resp_valid;
    logic                  resp_os;
    logic                  resp_hit;
    logic [NUM_WAYS-1:0]   resp_way;
    logic                  resp_err;

    modport master (
        output os_valid, os_addr, user_valid, user_addr,
               os_way_mask, user_way_mask, line_hitmap,
        input  os_ready, user_ready, line_os_req, line_user_req, line_addr,
               resp_valid, resp_os, resp_hit, resp_way, resp_err
    );

    modport slave (
        input  os_valid, os_addr, user_valid, user_addr,
               os_way_mask, user_way_mask, line_hitmap,
        output os_ready, user_ready, line_os_req, line_user_req, line_addr,
               resp_valid, resp_os, resp_hit, resp_way, resp_err
    );
endinterface

// File: rtl/cache_partition_arbiter.sv
// Arbitrates OS and user cache lookups, restricts hits to each domain's way
// partition and picks round-robin victims per domain on a miss.
module cache_partition_arbiter #(
    parameter int NUM_WAYS   = 4,
    parameter int ADDR_WIDTH = 8
) (
    input logic                      clk,
    input logic                      reset,
    cache_partition_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, RESOLVE, RESP} state_t;

    state_t              state;
    logic                owner_os;
    logic [NUM_WAYS-1:0] mask_q;
    logic                last_user;
    logic [PTR_W-1:0]    os_ptr;
    logic [PTR_W-1:0]    user_ptr;

    logic                grant_os;
    logic                grant_user;
    logic                in_idle;

    // A tie goes to the domain not granted last; last_user=1 out of reset hands the first tie to OS.
    assign in_idle        = (state == IDLE) && !reset;
    assign grant_os       = bus.os_valid && (!bus.user_valid || last_user);
    assign grant_user     = bus.user_valid && !grant_os;
    assign bus.os_ready   = in_idle && grant_os;
    assign bus.user_ready = in_idle && grant_user;

    logic [NUM_WAYS-1:0] masked;
    logic [NUM_WAYS-1:0] hit_way;
    logic                hit_found;
    logic [PTR_W-1:0]    ptr_cur;
    logic                hi_found;
    logic [PTR_W-1:0]    hi_idx;
    logic [NUM_WAYS-1:0] hi_way;
    logic                lo_found;
    logic [PTR_W-1:0]    lo_idx;
    logic [NUM_WAYS-1:0] lo_way;
    logic [PTR_W-1:0]    victim_idx;
    logic [NUM_WAYS-1:0] victim_way;
    logic [PTR_W-1:0]    ptr_next;

    // Victim search: first owned way at/after the pointer, else wrap to the first owned way.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        masked    = bus.line_hitmap & mask_q;
        ptr_cur   = owner_os ? os_ptr : user_ptr;
        hit_found = 1'b0;
        hit_way   = '0;
        hi_found  = 1'b0;
        hi_idx    = '0;
        hi_way    = '0;
        lo_found  = 1'b0;
        lo_idx    = '0;
        lo_way    = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (masked[i] && !hit_found) begin
                hit_found  = 1'b1;
                hit_way[i] = 1'b1;
            end
            if (mask_q[i] && !hi_found && (i >= int'(ptr_cur))) begin
                hi_found  = 1'b1;
                hi_idx    = PTR_W'(i);
                hi_way[i] = 1'b1;
            end
            if (mask_q[i] && !lo_found) begin
                lo_found  = 1'b1;
                lo_idx    = PTR_W'(i);
                lo_way[i] = 1'b1;
            end
        end
        victim_idx = hi_found ? hi_idx : lo_idx;
        victim_way = hi_found ? hi_way : lo_way;
        ptr_next   = (victim_idx == PTR_W'(NUM_WAYS - 1)) ? '0 : victim_idx + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state             <= IDLE;
            owner_os          <= 1'b0;
            mask_q            <= '0;
            last_user         <= 1'b1;
            os_ptr            <= '0;
            user_ptr          <= '0;
            bus.line_os_req   <= 1'b0;
            bus.line_user_req <= 1'b0;
            bus.line_addr     <= '0;
            bus.resp_valid    <= 1'b0;
            bus.resp_os       <= 1'b0;
            bus.resp_hit      <= 1'b0;
            bus.resp_way      <= '0;
            bus.resp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_os || grant_user) begin
                        state             <= LOOKUP;
                        owner_os          <= grant_os;
                        last_user         <= grant_user;
                        mask_q            <= grant_os ? bus.os_way_mask : bus.user_way_mask;
                        bus.line_addr     <= grant_os ? bus.os_addr : bus.user_addr;
                        bus.line_os_req   <= grant_os;
                        bus.line_user_req <= grant_user;
                    end
                end
                LOOKUP: begin
                    state <= RESOLVE;
                end
                RESOLVE: begin
                    state             <= RESP;
                    bus.line_os_req   <= 1'b0;
                    bus.line_user_req <= 1'b0;
                    bus.resp_valid    <= 1'b1;
                    bus.resp_os       <= owner_os;
                    if (mask_q == '0) begin
                        bus.resp_err <= 1'b1;
                        bus.resp_hit <= 1'b0;
                        bus.resp_way <= '0;
                    end else if (hit_found) begin
                        bus.resp_err <= 1'b0;
                        bus.resp_hit <= 1'b1;
                        bus.resp_way <= hit_way;
                    end else begin
                        bus.resp_err <= 1'b0;
                        bus.resp_hit <= 1'b0;
                        bus.resp_way <= victim_way;
                        if (owner_os) os_ptr <= ptr_next;
                        else          user_ptr <= ptr_next;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_os    <= 1'b0;
                    bus.resp_hit   <= 1'b0;
                    bus.resp_way   <= '0;
                    bus.resp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_partition_arbiter.sv
// Directed bench for cache_partition_arbiter: a vector table of complete transactions
// followed by hand-written reset and mask-latching sequences.
module tb_cache_partition_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    cache_partition_arbiter_if #(.NUM_WAYS(4), .ADDR_WIDTH(8)) bus ();

    cache_partition_arbiter #(.NUM_WAYS(4), .ADDR_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       os_v;
        logic       us_v;
        logic [3:0] os_m;
        logic [3:0] us_m;
        logic [3:0] os_m_late;
        logic [3:0] hit;
        logic       exp_os;
        logic       exp_hit;
        logic [3:0] exp_way;
        logic       exp_err;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic os_v, input logic us_v, input logic [3:0] os_m,
                                input logic [3:0] us_m, input logic [3:0] os_m_late,
                                input logic [3:0] hit, input logic exp_os, input logic exp_hit,
                                input logic [3:0] exp_way, input logic exp_err);
        vec_t v;
        v.os_v = os_v; v.us_v = us_v; v.os_m = os_m; v.us_m = us_m;
        v.os_m_late = os_m_late; v.hit = hit; v.exp_os = exp_os;
        v.exp_hit = exp_hit; v.exp_way = exp_way; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic next_negedge();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one full transaction starting at a negedge in IDLE and ends at the negedge back in IDLE.
    task automatic do_txn(input int idx, input vec_t v);
        logic [7:0] oa;
        logic [7:0] ua;
        oa = 8'h10 + 8'(idx);
        ua = 8'h80 + 8'(idx);
        bus.os_valid      = v.os_v;
        bus.user_valid    = v.us_v;
        bus.os_addr       = oa;
        bus.user_addr     = ua;
        bus.os_way_mask   = v.os_m;
        bus.user_way_mask = v.us_m;
        bus.line_hitmap   = v.hit;
        #1;
        check($sformatf("v%0d_os_ready", idx), 32'(bus.os_ready), 32'(v.exp_os));
        check($sformatf("v%0d_user_ready", idx), 32'(bus.user_ready), 32'(!v.exp_os));
        next_negedge();
        bus.os_valid    = 1'b0;
        bus.user_valid  = 1'b0;
        bus.os_way_mask = v.os_m_late;
        check($sformatf("v%0d_lookup_os_req", idx), 32'(bus.line_os_req), 32'(v.exp_os));
        check($sformatf("v%0d_lookup_user_req", idx), 32'(bus.line_user_req), 32'(!v.exp_os));
        check($sformatf("v%0d_line_addr", idx), 32'(bus.line_addr), 32'(v.exp_os ? oa : ua));
        check($sformatf("v%0d_lookup_no_resp", idx), 32'(bus.resp_valid), 32'd0);
        next_negedge();
        check($sformatf("v%0d_resolve_os_req", idx), 32'(bus.line_os_req), 32'(v.exp_os));
        next_negedge();
        check($sformatf("v%0d_resp_valid", idx), 32'(bus.resp_valid), 32'd1);
        check($sformatf("v%0d_resp_os", idx), 32'(bus.resp_os), 32'(v.exp_os));
        check($sformatf("v%0d_resp_hit", idx), 32'(bus.resp_hit), 32'(v.exp_hit));
        check($sformatf("v%0d_resp_way", idx), 32'(bus.resp_way), 32'(v.exp_way));
        check($sformatf("v%0d_resp_err", idx), 32'(bus.resp_err), 32'(v.exp_err));
        check($sformatf("v%0d_resp_line_req", idx), 32'({bus.line_os_req, bus.line_user_req}), 32'd0);
        next_negedge();
        check($sformatf("v%0d_idle_resp_valid", idx), 32'(bus.resp_valid), 32'd0);
        check($sformatf("v%0d_idle_resp_fields", idx),
              32'({bus.resp_hit, bus.resp_err, bus.resp_way}), 32'd0);
    endtask

    initial begin
        // Pointer trace (os/user): 0/0 -> v1 u:3 -> v2 u:0 -> v3 u:3 -> v5 o:1 -> v6 o:2 -> v7 o:1
        // -> v9 o:2 -> v10 u:0 -> v12 u:2 -> v14 u:3 -> v15 o:1
        //              os_v  us_v  os_m     us_m     os_late  hitmap   os  hit way      err
        vecs[0]  = mk(1'b1, 1'b1, 4'b0011, 4'b1100, 4'b0011, 4'b0110, 1, 1, 4'b0010, 0);
        vecs[1]  = mk(1'b1, 1'b1, 4'b0011, 4'b1100, 4'b0011, 4'b0011, 0, 0, 4'b0100, 0);
        vecs[2]  = mk(1'b0, 1'b1, 4'b0011, 4'b1100, 4'b0011, 4'b0011, 0, 0, 4'b1000, 0);
        vecs[3]  = mk(1'b0, 1'b1, 4'b0011, 4'b1100, 4'b0011, 4'b0011, 0, 0, 4'b0100, 0);
        vecs[4]  = mk(1'b1, 1'b0, 4'b0000, 4'b1100, 4'b0000, 4'b1111, 1, 0, 4'b0000, 1);
        vecs[5]  = mk(1'b1, 1'b0, 4'b0011, 4'b1100, 4'b0011, 4'b0000, 1, 0, 4'b0001, 0);
        vecs[6]  = mk(1'b1, 1'b0, 4'b0011, 4'b1100, 4'b0011, 4'b1100, 1, 0, 4'b0010, 0);
        vecs[7]  = mk(1'b1, 1'b0, 4'b0011, 4'b1100, 4'b0011, 4'b0000, 1, 0, 4'b0001, 0);
        vecs[8]  = mk(1'b1, 1'b0, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 1, 0, 4'b0000, 1);
        vecs[9]  = mk(1'b1, 1'b0, 4'b0011, 4'b1100, 4'b0011, 4'b0000, 1, 0, 4'b0010, 0);
        vecs[10] = mk(1'b1, 1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 0, 0, 4'b1000, 0);
        vecs[11] = mk(1'b1, 1'b1, 4'b0110, 4'b1111, 4'b0110, 4'b1110, 1, 1, 4'b0010, 0);
        vecs[12] = mk(1'b0, 1'b1, 4'b0110, 4'b0110, 4'b0110, 4'b0000, 0, 0, 4'b0010, 0);
        vecs[13] = mk(1'b0, 1'b1, 4'b0110, 4'b1111, 4'b0110, 4'b1000, 0, 1, 4'b1000, 0);
        vecs[14] = mk(1'b0, 1'b1, 4'b0110, 4'b1111, 4'b0110, 4'b0000, 0, 0, 4'b0100, 0);
        // Mask widened during LOOKUP; the latched 0011 must still be used, so the hit in way 3 is ignored.
        vecs[15] = mk(1'b1, 1'b0, 4'b0011, 4'b1111, 4'b1100, 4'b1000, 1, 0, 4'b0001, 0);

        reset             = 1'b1;
        bus.os_valid      = 1'b1;
        bus.user_valid    = 1'b1;
        bus.os_addr       = 8'h00;
        bus.user_addr     = 8'h00;
        bus.os_way_mask   = 4'b0000;
        bus.user_way_mask = 4'b0000;
        bus.line_hitmap   = 4'b0000;
        @(negedge clk);
        check("reset_os_ready", 32'(bus.os_ready), 32'd0);
        check("reset_user_ready", 32'(bus.user_ready), 32'd0);
        next_negedge();
        reset          = 1'b0;
        bus.os_valid   = 1'b0;
        bus.user_valid = 1'b0;
        #1;
        check("reset_line_req", 32'({bus.line_os_req, bus.line_user_req}), 32'd0);
        check("reset_line_addr", 32'(bus.line_addr), 32'd0);
        check("reset_resp", 32'({bus.resp_valid, bus.resp_os, bus.resp_hit, bus.resp_err, bus.resp_way}), 32'd0);
        check("reset_idle_ready", 32'({bus.os_ready, bus.user_ready}), 32'd0);

        for (int i = 0; i < 16; i++) do_txn(i, vecs[i]);

        // Reset while in RESOLVE: no response may follow, outputs clear, ready held low during reset.
        bus.os_valid    = 1'b1;
        bus.os_addr     = 8'h55;
        bus.os_way_mask = 4'b0011;
        bus.line_hitmap = 4'b0000;
        next_negedge();
        bus.os_valid = 1'b0;
        next_negedge();
        check("abort_in_resolve", 32'(bus.line_os_req), 32'd1);
        reset          = 1'b1;
        bus.os_valid   = 1'b1;
        bus.user_valid = 1'b1;
        #1;
        check("abort_reset_ready", 32'({bus.os_ready, bus.user_ready}), 32'd0);
        next_negedge();
        reset          = 1'b0;
        bus.os_valid   = 1'b0;
        bus.user_valid = 1'b0;
        #1;
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort_outputs", 32'({bus.line_os_req, bus.line_user_req, bus.line_addr,
                                    bus.resp_os, bus.resp_hit, bus.resp_err, bus.resp_way}), 32'd0);
        for (int c = 0; c < 3; c++) begin
            next_negedge();
            check($sformatf("abort_quiet_%0d", c), 32'(bus.resp_valid), 32'd0);
        end

        // After reset: OS wins the tie and both pointers restart at way 0.
        do_txn(16, mk(1'b1, 1'b1, 4'b0011, 4'b1100, 4'b0011, 4'b0000, 1, 0, 4'b0001, 0));
        do_txn(17, mk(1'b1, 1'b1, 4'b0011, 4'b1100, 4'b0011, 4'b0000, 0, 0, 4'b0100, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
